// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default
// oversampling ratio and the counter-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;

    // Bits needed to hold the value (at least 1).
    function automatic int clogb2(input int value);
        int v;
        int r;
        r = 0;
        for (v = value; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit,
// with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            meta <= RST_VAL;
            o_q  <= RST_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampled UART receiver: start detect, mid-bit sampling,
// LSB-first shift, stop check, one-cycle done strobe.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    localparam int TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int TICK_W   = clogb2(TICK_MAX - 1);
    localparam int BIT_W    = clogb2(NB_DATA - 1);

    localparam logic [TICK_W-1:0] MID_T  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] BIT_T  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_T = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  LAST_B = BIT_W'(NB_DATA - 1);

    logic rx_s;

    rx_state_t          state, state_n;
    logic [TICK_W-1:0]  tick_cnt, tick_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic [NB_DATA-1:0] shreg, shreg_n;
    logic [NB_DATA-1:0] data_n;
    logic               done_n;
    logic               ferr_n;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_d    (i_rx),
        .o_q    (rx_s)
    );

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        data_n  = o_data;
        ferr_n  = o_frame_err;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_cnt == MID_T) begin
                        tick_n = '0;
                        if (!rx_s) begin
                            state_n = DATA;
                            bit_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (tick_cnt == BIT_T) begin
                        tick_n  = '0;
                        shreg_n = {rx_s, shreg[NB_DATA-1:1]};
                        if (bit_cnt == LAST_B) begin
                            state_n = STOP;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (tick_cnt == STOP_T) begin
                        state_n = IDLE;
                        tick_n  = '0;
                        data_n  = shreg;
                        ferr_n  = ~rx_s;
                        done_n  = 1'b1;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            bit_cnt     <= bit_n;
            shreg       <= shreg_n;
            o_data      <= data_n;
            o_rx_done   <= done_n;
            o_frame_err <= ferr_n;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: tick every 4 clk, 64 clk
// per bit, done pulses captured by a negedge monitor.
module tb_uart_rx_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [7:0] cap_data [64];
    logic       cap_ferr [64];

    uart_rx_ctrl #(
        .NB_DATA(8),
        .SB_TICK(16),
        .OVERSAMPLE(16)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_rx_done  (o_rx_done),
        .o_frame_err(o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge i_clk);
            i_tick = (k == 3);
            k = (k == 3) ? 0 : k + 1;
        end
    end

    always @(negedge i_clk) begin
        if (o_rx_done) begin
            cap_data[done_cnt[5:0]] = o_data;
            cap_ferr[done_cnt[5:0]] = o_frame_err;
            done_cnt = done_cnt + 1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic drive_bit(input logic b, input int n);
        @(negedge i_clk);
        i_rx = b;
        repeat (n - 1) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0, 64);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 64);
        drive_bit(stop, 64);
    endtask

    task automatic chk_count(input string nm, input int base, input int exp);
        n_cmp++;
        if (done_cnt - base !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d done pulses, want %0d", nm, done_cnt - base, exp);
        end
    endtask

    task automatic test_reset();
        int base;
        base = done_cnt;
        i_reset = 1'b0;
        i_rx = 1'b0;
        wait_clk(5);
        n_cmp++;
        if (o_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 00", o_data);
        end
        n_cmp++;
        if (o_rx_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done: got %b want 0", o_rx_done);
        end
        n_cmp++;
        if (o_frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ferr: got %b want 0", o_frame_err);
        end
        i_rx = 1'b1;
        wait_clk(1);
        i_reset = 1'b1;
        wait_clk(64);
        chk_count("reset_no_done", base, 0);
    endtask

    task automatic test_frame(input string nm, input logic [7:0] d,
                              input logic stop);
        int base;
        base = done_cnt;
        send_frame(d, stop);
        drive_bit(1'b1, 128);
        chk_count(nm, base, 1);
        n_cmp++;
        if (cap_data[base[5:0]] !== d) begin
            n_bad++;
            $display("FAIL %s_data: got %h want %h", nm, cap_data[base[5:0]], d);
        end
        n_cmp++;
        if (cap_ferr[base[5:0]] !== ~stop) begin
            n_bad++;
            $display("FAIL %s_ferr: got %b want %b", nm, cap_ferr[base[5:0]], ~stop);
        end
    endtask

    task automatic test_glitch();
        int base;
        base = done_cnt;
        drive_bit(1'b0, 12);
        drive_bit(1'b1, 192);
        chk_count("glitch_no_done", base, 0);
        test_frame("glitch_then_3c", 8'h3C, 1'b1);
    endtask

    task automatic test_mid_reset();
        int base;
        base = done_cnt;
        drive_bit(1'b0, 64);
        drive_bit(1'b1, 64);
        drive_bit(1'b0, 64);
        drive_bit(1'b1, 64);
        drive_bit(1'b0, 32);
        i_reset = 1'b0;
        wait_clk(3);
        n_cmp++;
        if (o_data !== 8'h00 || o_frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_regs: got data %h ferr %b want 00 0",
                     o_data, o_frame_err);
        end
        i_rx = 1'b1;
        wait_clk(1);
        i_reset = 1'b1;
        drive_bit(1'b1, 704);
        chk_count("midreset_no_done", base, 0);
        test_frame("after_reset_81", 8'h81, 1'b1);
    endtask

    task automatic test_back_to_back();
        int base;
        base = done_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive_bit(1'b1, 128);
        chk_count("b2b_count", base, 2);
        n_cmp++;
        if (cap_data[base[5:0]] !== 8'h00 || cap_ferr[base[5:0]] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_first: got %h/%b want 00/0",
                     cap_data[base[5:0]], cap_ferr[base[5:0]]);
        end
        n_cmp++;
        if (cap_data[base[5:0]+6'd1] !== 8'hFF || cap_ferr[base[5:0]+6'd1] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_second: got %h/%b want FF/0",
                     cap_data[base[5:0]+6'd1], cap_ferr[base[5:0]+6'd1]);
        end
    endtask

    task automatic test_hold();
        n_cmp++;
        if (o_data !== 8'hFF || o_rx_done !== 1'b0) begin
            n_bad++;
            $display("FAIL hold: got data %h done %b want FF 0", o_data, o_rx_done);
        end
    endtask

    initial begin
        test_reset();
        test_frame("frame_a5", 8'hA5, 1'b1);
        test_glitch();
        test_frame("bad_stop_ff", 8'hFF, 1'b0);
        test_mid_reset();
        test_back_to_back();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
